// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the CPU MEM stage and a DMA engine, with DMA starvation guard and burst lock.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on CPU/DMA contention instead of fixed CPU priority.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic        dma_lock,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_valid,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] { IDLE, CPU_OWN, DMA_LOCK } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_next;
    logic       cpu_act;
    logic       dma_starved;
    logic       burst_held;
    logic       cpu_win;
    logic       dma_win;
    logic       rd_issue;

    assign cpu_act     = cpu_rd | cpu_wr;
    // Starvation only matters while DMA is actually asking; a withdrawn request must not block the CPU.
    assign dma_starved = dma_req & (wait_cnt >= LIMIT);
    assign burst_held  = (state == DMA_LOCK) & dma_req & dma_lock;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_cpu;
    logic contend;

    assign contend = cpu_act & dma_req & ~dma_starved;
`endif

    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        if (!reset) begin
            if (burst_held) begin
                dma_win = 1'b1;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            else if (contend) begin
                dma_win = last_cpu;
                cpu_win = ~last_cpu;
            end
`endif
            else if (cpu_act && !dma_starved) begin
                cpu_win = 1'b1;
            end else if (dma_req) begin
                dma_win = 1'b1;
            end
        end
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (dma_win) begin
            mem_rd    = ~dma_wr;
            mem_wr    = dma_wr;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (cpu_win) begin
            // Simultaneous rd and wr from the CPU resolves to a write.
            mem_rd    = cpu_rd & ~cpu_wr;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    assign cpu_stall = cpu_act & ~cpu_win & ~reset;
    assign dma_gnt   = dma_req & dma_win;
    assign rd_issue  = dma_gnt & ~dma_wr;

    always_comb begin
        wait_cnt_next = wait_cnt;
        if (dma_gnt) begin
            wait_cnt_next = 4'd0;
        end else if (dma_req && (wait_cnt < LIMIT)) begin
            wait_cnt_next = wait_cnt + 4'd1;
        end
    end

    always_comb begin
        state_next = IDLE;
        if (dma_gnt && dma_lock) begin
            state_next = DMA_LOCK;
        end else if (cpu_win) begin
            state_next = CPU_OWN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read data returns one cycle after the granted DMA read; dma_rdata holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= 4'd0;
            dma_valid <= 1'b0;
            dma_rdata <= 32'h0;
        end else begin
            wait_cnt  <= wait_cnt_next;
            dma_valid <= rd_issue;
            if (rd_issue) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_cpu <= 1'b1;
        end else if (cpu_win) begin
            last_cpu <= 1'b1;
        end else if (dma_win) begin
            last_cpu <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected bus/response values are queued as stimulus is driven and compared each cycle.
module tb_mem_arbiter;
    localparam int STARVE_LIMIT = 8;

    logic        clk;
    logic        reset;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_wr;
    logic        dma_lock;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_valid;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        stall;
        logic        gnt;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    bus_t exp_bus;
    rsp_t exp_rsp;
    int   vectors = 0;
    int   miscompares = 0;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_lock(dma_lock),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_valid(dma_valid),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bus_t mk(input logic s, input logic g, input logic r, input logic w,
                                input logic [31:0] a, input logic [31:0] d);
        return {s, g, r, w, a, d};
    endfunction

    function automatic bus_t bus_now();
        return {cpu_stall, dma_gnt, mem_rd, mem_wr, mem_addr, mem_wdata};
    endfunction

    function automatic rsp_t rsp_now();
        return {dma_valid, dma_rdata};
    endfunction

    task automatic idle_inputs();
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_wr = 1'b0; dma_lock = 1'b0;
        dma_addr = 32'h0; dma_wdata = 32'h0; mem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h4000_0000;
        dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 32'h10;
        bus_q.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0));
        rsp_q.push_back({1'b0, 32'h0});
        #1;
        exp_bus = bus_q.pop_front();
        vectors++;
        if (bus_now() !== exp_bus) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want %h", bus_now(), exp_bus);
        end
        exp_rsp = rsp_q.pop_front();
        vectors++;
        if (rsp_now() !== exp_rsp) begin
            miscompares++;
            $display("FAIL reset_rsp: got %h want %h", rsp_now(), exp_rsp);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_cpu_only();
        bus_t pat[3];
        pat[0] = mk(0, 0, 1, 0, 32'h4000_0010, 32'h1111_2222);
        pat[1] = mk(0, 0, 0, 1, 32'h4000_0014, 32'hCAFE_F00D);
        pat[2] = mk(0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_inputs();
            if (i == 0) begin
                cpu_rd = 1'b1; cpu_addr = 32'h4000_0010; cpu_wdata = 32'h1111_2222;
            end else if (i == 1) begin
                cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h4000_0014; cpu_wdata = 32'hCAFE_F00D;
            end
            bus_q.push_back(pat[i]);
            #1;
            exp_bus = bus_q.pop_front();
            vectors++;
            if (bus_now() !== exp_bus) begin
                miscompares++;
                $display("FAIL cpu_only_%0d: got %h want %h", i, bus_now(), exp_bus);
            end
        end
    endtask

    task automatic test_dma_read();
        @(negedge clk);
        idle_inputs();
        dma_req = 1'b1; dma_addr = 32'h20; mem_rdata = 32'hDEAD_BEEF;
        bus_q.push_back(mk(0, 1, 1, 0, 32'h20, 32'h0));
        #1;
        exp_bus = bus_q.pop_front();
        vectors++;
        if (bus_now() !== exp_bus) begin
            miscompares++;
            $display("FAIL dma_read_grant: got %h want %h", bus_now(), exp_bus);
        end

        @(negedge clk);
        idle_inputs();
        mem_rdata = 32'h0BAD_0BAD;
        rsp_q.push_back({1'b1, 32'hDEAD_BEEF});
        #1;
        exp_rsp = rsp_q.pop_front();
        vectors++;
        if (rsp_now() !== exp_rsp) begin
            miscompares++;
            $display("FAIL dma_read_data: got %h want %h", rsp_now(), exp_rsp);
        end

        @(negedge clk);
        dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'h24; dma_wdata = 32'h0055_AA00;
        bus_q.push_back(mk(0, 1, 0, 1, 32'h24, 32'h0055_AA00));
        rsp_q.push_back({1'b0, 32'hDEAD_BEEF});
        #1;
        exp_rsp = rsp_q.pop_front();
        vectors++;
        if (rsp_now() !== exp_rsp) begin
            miscompares++;
            $display("FAIL dma_rdata_hold: got %h want %h", rsp_now(), exp_rsp);
        end
        exp_bus = bus_q.pop_front();
        vectors++;
        if (bus_now() !== exp_bus) begin
            miscompares++;
            $display("FAIL dma_write_grant: got %h want %h", bus_now(), exp_bus);
        end

        @(negedge clk);
        idle_inputs();
        rsp_q.push_back({1'b0, 32'hDEAD_BEEF});
        #1;
        exp_rsp = rsp_q.pop_front();
        vectors++;
        if (rsp_now() !== exp_rsp) begin
            miscompares++;
            $display("FAIL dma_write_no_valid: got %h want %h", rsp_now(), exp_rsp);
        end
    endtask

`ifndef MEM_ARB_ROUND_ROBIN_EN
    task automatic test_starvation();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h4000_0100; cpu_wdata = 32'h0;
            dma_req = 1'b1; dma_wr = 1'b0; dma_lock = 1'b0; dma_addr = 32'h80; dma_wdata = 32'h0;
            mem_rdata = 32'h1234_5678;
            if (i == 8) bus_q.push_back(mk(1, 1, 1, 0, 32'h80, 32'h0));
            else        bus_q.push_back(mk(0, 0, 1, 0, 32'h4000_0100, 32'h0));
            if (i == 8) rsp_q.push_back({1'b0, 32'hDEAD_BEEF});
            if (i == 9) rsp_q.push_back({1'b1, 32'h1234_5678});
            #1;
            exp_bus = bus_q.pop_front();
            vectors++;
            if (bus_now() !== exp_bus) begin
                miscompares++;
                $display("FAIL starve_c%0d: got %h want %h", i, bus_now(), exp_bus);
            end
            if (i >= 8) begin
                exp_rsp = rsp_q.pop_front();
                vectors++;
                if (rsp_now() !== exp_rsp) begin
                    miscompares++;
                    $display("FAIL starve_rsp_c%0d: got %h want %h", i, rsp_now(), exp_rsp);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_withdrawal();
        @(negedge clk);
        idle_inputs();
        dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'h90; dma_wdata = 32'h77;
        bus_q.push_back(mk(0, 1, 0, 1, 32'h90, 32'h77));
        #1;
        exp_bus = bus_q.pop_front();
        vectors++;
        if (bus_now() !== exp_bus) begin
            miscompares++;
            $display("FAIL withdraw_clear: got %h want %h", bus_now(), exp_bus);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cpu_wr = 1'b1; cpu_addr = 32'h4000_0200; cpu_wdata = 32'hBEEF_0000;
            dma_req = !(i >= 5 && i < 8);
            if (i == 11) bus_q.push_back(mk(1, 1, 0, 1, 32'h90, 32'h77));
            else         bus_q.push_back(mk(0, 0, 0, 1, 32'h4000_0200, 32'hBEEF_0000));
            #1;
            exp_bus = bus_q.pop_front();
            vectors++;
            if (bus_now() !== exp_bus) begin
                miscompares++;
                $display("FAIL withdraw_c%0d: got %h want %h", i, bus_now(), exp_bus);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask
`else
    task automatic test_round_robin();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cpu_rd = 1'b1; cpu_addr = 32'h4000_0500; cpu_wdata = 32'h0;
            dma_req = 1'b1; dma_wr = 1'b1; dma_lock = 1'b0; dma_addr = 32'h300; dma_wdata = 32'h33;
            if (i % 2 == 0) bus_q.push_back(mk(1, 1, 0, 1, 32'h300, 32'h33));
            else            bus_q.push_back(mk(0, 0, 1, 0, 32'h4000_0500, 32'h0));
            #1;
            exp_bus = bus_q.pop_front();
            vectors++;
            if (bus_now() !== exp_bus) begin
                miscompares++;
                $display("FAIL rr_c%0d: got %h want %h", i, bus_now(), exp_bus);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask
`endif

    task automatic test_lock();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dma_req = 1'b1; dma_wr = 1'b1; dma_lock = (i < 5);
            dma_addr = 32'h100 + 32'(4 * i); dma_wdata = 32'hD0 + 32'(i);
            cpu_wr = (i > 0); cpu_addr = 32'h4000_0300; cpu_wdata = 32'hC0;
            if (i == 0)      bus_q.push_back(mk(0, 1, 0, 1, 32'h100, 32'hD0));
            else if (i < 5)  bus_q.push_back(mk(1, 1, 0, 1, 32'h100 + 32'(4 * i), 32'hD0 + 32'(i)));
            else             bus_q.push_back(mk(0, 0, 0, 1, 32'h4000_0300, 32'hC0));
            #1;
            exp_bus = bus_q.pop_front();
            vectors++;
            if (bus_now() !== exp_bus) begin
                miscompares++;
                $display("FAIL lock_c%0d: got %h want %h", i, bus_now(), exp_bus);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_burst();
        int n;
        @(negedge clk);
        idle_inputs();
        dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 32'h200; mem_rdata = 32'hA5A5_A5A5;
        bus_q.push_back(mk(0, 1, 1, 0, 32'h200, 32'h0));
        #1;
        exp_bus = bus_q.pop_front();
        vectors++;
        if (bus_now() !== exp_bus) begin
            miscompares++;
            $display("FAIL burst_grant: got %h want %h", bus_now(), exp_bus);
        end

        @(negedge clk);
        reset = 1'b1;
        bus_q.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0));
        rsp_q.push_back({1'b1, 32'hA5A5_A5A5});
        #1;
        exp_bus = bus_q.pop_front();
        vectors++;
        if (bus_now() !== exp_bus) begin
            miscompares++;
            $display("FAIL burst_in_reset: got %h want %h", bus_now(), exp_bus);
        end
        exp_rsp = rsp_q.pop_front();
        vectors++;
        if (rsp_now() !== exp_rsp) begin
            miscompares++;
            $display("FAIL burst_rsp_pre: got %h want %h", rsp_now(), exp_rsp);
        end

`ifdef MEM_ARB_ROUND_ROBIN_EN
        n = 1;
`else
        n = 9;
`endif
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b0;
            cpu_wr = 1'b1; cpu_addr = 32'h4000_0400; cpu_wdata = 32'hE0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            bus_q.push_back(mk(1, 1, 1, 0, 32'h200, 32'h0));
`else
            if (i == 8) bus_q.push_back(mk(1, 1, 1, 0, 32'h200, 32'h0));
            else        bus_q.push_back(mk(0, 0, 0, 1, 32'h4000_0400, 32'hE0));
`endif
            if (i == 0) rsp_q.push_back({1'b0, 32'h0});
            #1;
            exp_bus = bus_q.pop_front();
            vectors++;
            if (bus_now() !== exp_bus) begin
                miscompares++;
                $display("FAIL after_reset_c%0d: got %h want %h", i, bus_now(), exp_bus);
            end
            if (i == 0) begin
                exp_rsp = rsp_q.pop_front();
                vectors++;
                if (rsp_now() !== exp_rsp) begin
                    miscompares++;
                    $display("FAIL burst_abort_rsp: got %h want %h", rsp_now(), exp_rsp);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_cpu_only();
        test_dma_read();
`ifndef MEM_ARB_ROUND_ROBIN_EN
        test_starvation();
        test_withdrawal();
`else
        test_round_robin();
`endif
        test_lock();
        test_reset_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
